// File: rtl/cnn_pkg.sv
// Shared types and sizes for the conv sequencer.
// Element counts are fixed to the 4x4 tile / 3x3 kernel datapath.
package cnn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_KER,
    LOAD_TILE,
    COMPUTE,
    DRAIN
  } state_t;

  localparam int KER_ELEMS  = 9;
  localparam int TILE_ELEMS = 16;
  localparam int OUT_ELEMS  = 4;
  localparam int CNT_W      = 5;

endpackage

// File: rtl/cnn_conv_sequencer_if.sv
// Byte-stream handshakes into and out of the conv sequencer.
// The slave side is the sequencer; the master side feeds and drains it.
interface cnn_conv_sequencer_if #(
  parameter int DATA_W = 8
);

  logic              in_valid_i;
  logic [DATA_W-1:0] in_data_i;
  logic              in_ready_o;
  logic              out_valid_o;
  logic [DATA_W-1:0] out_data_o;
  logic              out_last_o;
  logic              out_ready_i;

  modport slave (
    input  in_valid_i,
    input  in_data_i,
    output in_ready_o,
    output out_valid_o,
    output out_data_o,
    output out_last_o,
    input  out_ready_i
  );

  modport master (
    output in_valid_i,
    output in_data_i,
    input  in_ready_o,
    input  out_valid_o,
    input  out_data_o,
    input  out_last_o,
    output out_ready_i
  );

endinterface

// File: rtl/cnn_conv_sequencer.sv
// Loads kernel/tile bytes into registers for the conv datapath,
// waits for the result and streams the four output bytes back.
module cnn_conv_sequencer
  import cnn_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int TILE_N      = 4,
  parameter int KER_N       = 3,
  parameter int COMPUTE_LAT = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start_i,
  input  logic                           reload_ker_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [KER_N*KER_N*DATA_W-1:0]  ker_flat_o,
  output logic [TILE_N*TILE_N*DATA_W-1:0] tile_flat_o,
  input  logic [OUT_ELEMS*DATA_W-1:0]    res_flat_i,
  cnn_conv_sequencer_if.slave            bus
);

  state_t r_state;

  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_lat;
  logic             r_kld;

  logic [KER_N*KER_N-1:0][DATA_W-1:0]   r_ker;
  logic [TILE_N*TILE_N-1:0][DATA_W-1:0] r_tile;
  logic [OUT_ELEMS-1:0][DATA_W-1:0]     r_res;

  logic              r_busy;
  logic              r_done;
  logic              r_in_rdy;
  logic              r_out_vld;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last;

  logic       w_in_hs;
  logic       w_out_hs;
  logic [1:0] w_nidx;

  assign w_in_hs  = bus.in_valid_i & r_in_rdy;
  assign w_out_hs = r_out_vld & bus.out_ready_i;
  assign w_nidx   = r_cnt[1:0] + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_lat      <= '0;
      r_kld      <= 1'b0;
      r_ker      <= '0;
      r_tile     <= '0;
      r_res      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_in_rdy   <= 1'b0;
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_out_last <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start_i) begin
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_in_rdy <= 1'b1;
            if (reload_ker_i | ~r_kld) r_state <= LOAD_KER;
            else                       r_state <= LOAD_TILE;
          end
        end
        LOAD_KER: begin
          if (w_in_hs) begin
            r_ker[r_cnt[3:0]] <= bus.in_data_i;
            if (r_cnt == 5'(KER_ELEMS-1)) begin
              r_cnt   <= '0;
              r_kld   <= 1'b1;
              r_state <= LOAD_TILE;
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
        end
        LOAD_TILE: begin
          if (w_in_hs) begin
            r_tile[r_cnt[3:0]] <= bus.in_data_i;
            if (r_cnt == 5'(TILE_ELEMS-1)) begin
              r_cnt    <= '0;
              r_lat    <= '0;
              r_in_rdy <= 1'b0;
              r_state  <= COMPUTE;
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
        end
        COMPUTE: begin
          // the datapath is combinational on the held regs
          if (r_lat == 8'(COMPUTE_LAT-1)) begin
            r_res      <= res_flat_i;
            r_out_vld  <= 1'b1;
            r_out_data <= res_flat_i[DATA_W-1:0];
            r_out_last <= 1'b0;
            r_state    <= DRAIN;
          end else begin
            r_lat <= r_lat + 8'd1;
          end
        end
        DRAIN: begin
          if (w_out_hs) begin
            if (r_cnt == 5'(OUT_ELEMS-1)) begin
              r_cnt      <= '0;
              r_out_vld  <= 1'b0;
              r_out_data <= '0;
              r_out_last <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= IDLE;
            end else begin
              r_cnt      <= r_cnt + 5'd1;
              r_out_data <= r_res[w_nidx];
              r_out_last <= (w_nidx == 2'(OUT_ELEMS-1));
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy_o          = r_busy;
  assign done_o          = r_done;
  assign ker_flat_o      = r_ker;
  assign tile_flat_o     = r_tile;
  assign bus.in_ready_o  = r_in_rdy;
  assign bus.out_valid_o = r_out_vld;
  assign bus.out_data_o  = r_out_data;
  assign bus.out_last_o  = r_out_last;

endmodule
